// File: rtl/camera_mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : camera_mode_sequencer
//  Brief    : N-stage bring-up sequencer for the camera register programmer.
//             Walks `mode` 0..NUM_STAGES-1. Each stage >= 1 needs `ready` to
//             stay high for DWELL_CYCLES cycles. Programmer errors restart the
//             sequence from stage 0 a bounded number of times, then raise a
//             sticky fault.
//  Options  : CAMERA_SEQ_WATCHDOG_EN - adds a READY_TIMEOUT watchdog on the
//             wait for `ready`. A timeout is handled exactly like an error.
//  Revision : 1.0 - initial release
// ============================================================================
module camera_mode_sequencer #(
  parameter int MODE_WIDTH    = 2,
  parameter int NUM_STAGES    = 3,         // 2 .. 2**MODE_WIDTH
  parameter int DWELL_CYCLES  = 67108864,  // >= 1
  parameter int READY_TIMEOUT = 48000000,  // used only with the watchdog
  parameter int MAX_RETRIES   = 3          // >= 1
) (
  input  logic                               clk_in,
  input  logic                               RESETn,
  input  logic                               ready,
  input  logic                               model_err,
  input  logic                               nack_err,
  input  logic                               hold,
  input  logic                               restart,
  output logic [MODE_WIDTH-1:0]              mode,
  output logic                               stage_done,
  output logic                               busy,
  output logic                               fault,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
);

  localparam int DW = $clog2(DWELL_CYCLES + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1);

  localparam logic [DW-1:0]         DWELL_LAST = DW'(DWELL_CYCLES - 1);
  localparam logic [RW-1:0]         RETRY_MAX  = RW'(MAX_RETRIES);
  localparam logic [MODE_WIDTH-1:0] LAST_MODE  = MODE_WIDTH'(NUM_STAGES - 1);

  typedef enum logic [1:0] {
    WAIT_READY = 2'd0,
    DWELL      = 2'd1,
    DONE       = 2'd2,
    FAULT      = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [MODE_WIDTH-1:0]   mode_q, mode_d;
  logic [RW-1:0]           retry_q, retry_d;
  logic [DW-1:0]           dwell_q, dwell_d;
  logic                    stage_done_q, stage_done_d;
  logic                    busy_q, busy_d;
  logic                    fault_q, fault_d;
  logic                    clr_cnt;    // clear both counters this cycle
  logic                    wdog_fire;  // watchdog limit reached this cycle
  logic                    err_w;
  logic [MODE_WIDTH-1:0]   mode_inc;

`ifdef CAMERA_SEQ_WATCHDOG_EN
  localparam int TW = $clog2(READY_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(READY_TIMEOUT - 1);

  logic [TW-1:0] tmo_q, tmo_d;

  // The watchdog fires on the cycle that would bring the count to READY_TIMEOUT.
  assign wdog_fire = (state_q == WAIT_READY) && !hold && !ready && (tmo_q == TMO_LAST);

  // Timeout counter: counts non-hold cycles spent waiting with ready low.
  always_comb begin
    tmo_d = tmo_q;
    if (clr_cnt) begin
      tmo_d = '0;
    end else if ((state_q == WAIT_READY) && !hold && !ready) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  // Timeout counter register.
  always_ff @(posedge clk_in) begin
    if (!RESETn) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`else
  // Without the watchdog the wait for ready is unbounded.
  assign wdog_fire = 1'b0;
`endif

  assign err_w    = (((model_err || nack_err) &&
                      ((state_q == WAIT_READY) || (state_q == DWELL))) || wdog_fire);
  assign mode_inc = mode_q + MODE_WIDTH'(1);

  // Next-state and output decode; restart beats errors, errors beat advance.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    retry_d      = retry_q;
    dwell_d      = dwell_q;
    stage_done_d = 1'b0;
    clr_cnt      = 1'b0;

    if (restart) begin
      state_d = WAIT_READY;
      mode_d  = '0;
      retry_d = '0;
      clr_cnt = 1'b1;
    end else if (err_w) begin
      mode_d  = '0;
      clr_cnt = 1'b1;
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + RW'(1);
        state_d = WAIT_READY;
      end else begin
        state_d = FAULT;
      end
    end else if (!hold) begin
      case (state_q)
        WAIT_READY: begin
          if (ready) begin
            clr_cnt = 1'b1;
            if (mode_q == '0) begin
              // Stage 0 has no dwell: advance on the first ready.
              mode_d       = mode_inc;
              stage_done_d = 1'b1;
              state_d      = (mode_inc == LAST_MODE) ? DONE : WAIT_READY;
            end else begin
              state_d = DWELL;
            end
          end
        end
        DWELL: begin
          if (!ready) begin
            state_d = WAIT_READY;
            clr_cnt = 1'b1;
          end else if (dwell_q == DWELL_LAST) begin
            mode_d       = mode_inc;
            stage_done_d = 1'b1;
            state_d      = (mode_inc == LAST_MODE) ? DONE : WAIT_READY;
            clr_cnt      = 1'b1;
          end else begin
            dwell_d = dwell_q + DW'(1);
          end
        end
        default: begin
          // DONE and FAULT ignore the programmer status.
        end
      endcase
    end

    if (clr_cnt) dwell_d = '0;

    busy_d  = (state_d == WAIT_READY) || (state_d == DWELL);
    fault_d = (state_d == FAULT);
  end

  // State and registered outputs.
  always_ff @(posedge clk_in) begin
    if (!RESETn) begin
      state_q      <= WAIT_READY;
      mode_q       <= '0;
      retry_q      <= '0;
      dwell_q      <= '0;
      stage_done_q <= 1'b0;
      busy_q       <= 1'b1;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      retry_q      <= retry_d;
      dwell_q      <= dwell_d;
      stage_done_q <= stage_done_d;
      busy_q       <= busy_d;
      fault_q      <= fault_d;
    end
  end

  assign mode        = mode_q;
  assign stage_done  = stage_done_q;
  assign busy        = busy_q;
  assign fault       = fault_q;
  assign retry_count = retry_q;

endmodule
`default_nettype wire

// File: tb/tb_camera_mode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_camera_mode_sequencer
//  Brief    : Directed self-checking bench for camera_mode_sequencer with
//             NUM_STAGES=3, DWELL_CYCLES=8, READY_TIMEOUT=16, MAX_RETRIES=2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_camera_mode_sequencer;

  logic       clk_in = 1'b0;
  logic       RESETn;
  logic       ready;
  logic       model_err;
  logic       nack_err;
  logic       hold;
  logic       restart;
  logic [1:0] mode;
  logic       stage_done;
  logic       busy;
  logic       fault;
  logic [1:0] retry_count;

  int n_tests = 0;
  int n_fail  = 0;

  camera_mode_sequencer #(
    .MODE_WIDTH    (2),
    .NUM_STAGES    (3),
    .DWELL_CYCLES  (8),
    .READY_TIMEOUT (16),
    .MAX_RETRIES   (2)
  ) u_dut (
    .clk_in      (clk_in),
    .RESETn      (RESETn),
    .ready       (ready),
    .model_err   (model_err),
    .nack_err    (nack_err),
    .hold        (hold),
    .restart     (restart),
    .mode        (mode),
    .stage_done  (stage_done),
    .busy        (busy),
    .fault       (fault),
    .retry_count (retry_count)
  );

  always #5 clk_in = ~clk_in;

  // One active edge, then settle so outputs are sampled away from the edge.
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    RESETn = 1'b0;
    tick(2);
    RESETn = 1'b1;
  endtask

  initial begin
    RESETn = 1'b0; ready = 1'b1; model_err = 1'b0; nack_err = 1'b0;
    hold = 1'b0; restart = 1'b0;

    // ---------------- Reset, then ready ----------------
    tick(2);
    check_eq("rst_mode",  mode, 0);
    check_eq("rst_sd",    stage_done, 0);
    check_eq("rst_busy",  busy, 1);
    check_eq("rst_fault", fault, 0);
    check_eq("rst_retry", retry_count, 0);
    RESETn = 1'b1;
    tick();
    check_eq("s0_mode", mode, 1);
    check_eq("s0_sd",   stage_done, 1);
    tick();                              // enter DWELL
    check_eq("s1_sd_low", stage_done, 0);
    tick(7);
    check_eq("s1_mode_hold", mode, 1);
    tick();                              // 9 cycles after mode became 1
    check_eq("s1_mode", mode, 2);
    check_eq("s1_sd",   stage_done, 1);
    check_eq("done_busy", busy, 0);
    tick();
    check_eq("done_sd_low", stage_done, 0);
    // DONE ignores errors
    nack_err = 1'b1; tick(); nack_err = 1'b0; tick();
    check_eq("done_err_retry", retry_count, 0);
    check_eq("done_err_mode",  mode, 2);

    // ---------------- Mid-operation reset ----------------
    RESETn = 1'b0; tick(); RESETn = 1'b1;
    check_eq("midrst_mode",  mode, 0);
    check_eq("midrst_busy",  busy, 1);
    check_eq("midrst_fault", fault, 0);

    // ---------------- Ready glitch in DWELL ----------------
    ready = 1'b1;
    do_reset();
    tick();                              // mode 1
    tick();                              // DWELL, count 0
    tick(5);                             // 5 dwell cycles
    ready = 1'b0; tick();                // back to WAIT_READY
    check_eq("glitch_mode0", mode, 1);
    ready = 1'b1; tick();                // DWELL again
    tick(7);
    check_eq("glitch_mode1", mode, 1);
    tick();
    check_eq("glitch_adv",   mode, 2);
    check_eq("glitch_sd",    stage_done, 1);

    // ---------------- Errors to fault ----------------
    do_reset();
    tick();                              // mode 1
    tick();                              // DWELL
    nack_err = 1'b1; tick(); nack_err = 1'b0;
    check_eq("err1_retry", retry_count, 1);
    check_eq("err1_mode",  mode, 0);
    check_eq("err1_sd",    stage_done, 0);
    check_eq("err1_busy",  busy, 1);
    tick();                              // stage 0 -> mode 1
    check_eq("err1_readv", mode, 1);
    nack_err = 1'b1; tick(); nack_err = 1'b0;
    check_eq("err2_retry", retry_count, 2);
    check_eq("err2_mode",  mode, 0);
    tick();
    nack_err = 1'b1; tick(); nack_err = 1'b0;
    check_eq("flt_fault", fault, 1);
    check_eq("flt_mode",  mode, 0);
    check_eq("flt_busy",  busy, 0);
    check_eq("flt_retry", retry_count, 2);
    tick(3);
    check_eq("flt_sticky", fault, 1);
    restart = 1'b1; tick(); restart = 1'b0;
    check_eq("rs_fault", fault, 0);
    check_eq("rs_retry", retry_count, 0);
    check_eq("rs_busy",  busy, 1);
    check_eq("rs_mode",  mode, 0);
    // Error coinciding with a stage-0 advance: error wins
    model_err = 1'b1; tick(); model_err = 1'b0;
    check_eq("coinc_mode",  mode, 0);
    check_eq("coinc_sd",    stage_done, 0);
    check_eq("coinc_retry", retry_count, 1);

    // ---------------- Hold ----------------
    do_reset();
    tick();                              // mode 1
    tick();                              // DWELL, count 0
    hold = 1'b1;
    tick(20);
    check_eq("hold_mode", mode, 1);
    check_eq("hold_sd",   stage_done, 0);
    hold = 1'b0;
    tick(7);
    check_eq("hold_pre", mode, 1);
    tick();
    check_eq("hold_adv", mode, 2);

    // ---------------- Watchdog ----------------
    ready = 1'b0;
    do_reset();
`ifdef CAMERA_SEQ_WATCHDOG_EN
    tick(15);
    check_eq("wd_pre",   retry_count, 0);
    tick();
    check_eq("wd_fire",  retry_count, 1);
    check_eq("wd_mode",  mode, 0);
`else
    tick(100);
    check_eq("nowd_retry", retry_count, 0);
    check_eq("nowd_busy",  busy, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
